operand_fetch_unit: RTL and testbench
=====================================

Name: operand_fetch_unit

Overview:
- Memory-operand fetch stage directly downstream of the stage-2 address selector.
- Consumes the selected 16-bit operand address and runs the data-memory read handshake.
- Supports single-level [addr] and double-indirect [[addr]] operands.
- Delivers the operand to the execute-stage operand buffer and stalls the upstream pipeline while a fetch is outstanding.

Parameters:
- ADDR_WIDTH, 16: width of operand address and memory address bus.
- DATA_WIDTH, 16: width of memory data and operand; must equal ADDR_WIDTH, because the indirect pointer is reused as an address.
- MAX_WAIT, 8: cycles a request state waits for memReady before aborting; legal range 1..255.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush; abandons any fetch.
- startFetch  input  1  upstream request; addrIn valid this cycle.
- indirect  input  1  sampled with startFetch; 1 = double-indirect [[addrIn]].
- addrIn  input  ADDR_WIDTH  operand address from the address selector.
- memReadData  input  DATA_WIDTH  data-memory read data, valid when memReady=1.
- memReady  input  1  data memory completes the current read this cycle.
- memWrite  input  1  a store is committing this cycle (used only by the optional feature).
- memWriteAddr  input  ADDR_WIDTH  address of that store (used only by the optional feature).
- memAddr  output  ADDR_WIDTH  registered read address to data memory.
- memRead  output  1  registered read request.
- operandOut  output  DATA_WIDTH  fetched operand, held until the next completion.
- operandValid  output  1  one-cycle pulse: operandOut is new.
- fetchError  output  1  one-cycle pulse: request timed out.
- stall  output  1  combinational hold to upstream stages.

Behaviour:
- Reset: state=IDLE, waitCnt=0; memAddr=0, memRead=0, operandOut=0, operandValid=0, fetchError=0, stall=0. Reset overrides flush and all inputs.
- States: IDLE, REQ1, REQ2, DONE.
- IDLE, startFetch=1:
  - latch addrIn into addrLatch and indirect into indLatch.
  - drive memAddr<=addrIn and memRead<=1.
  - next state REQ1, waitCnt<=0.
- REQ1, memReady=1:
  - if indLatch, memAddr<=memReadData, memRead stays 1, next state REQ2, waitCnt<=0.
  - else operandOut<=memReadData, memRead<=0, next state DONE.
- REQ2, memReady=1: operandOut<=memReadData, memRead<=0, next state DONE.
- REQ1/REQ2, memReady=0:
  - waitCnt increments.
  - when waitCnt==MAX_WAIT-1 and memReady=0: memRead<=0, fetchError<=1 for one cycle, operandOut unchanged, next state IDLE.
- DONE:
  - operandValid=1 for exactly this cycle.
  - if startFetch=1, accept the new request exactly as from IDLE (back-to-back); else go to IDLE.
- Latency, zero-wait memory:
  - single-level: operandValid 2 cycles after the startFetch edge.
  - indirect: 3 cycles.
- stall = (state==REQ1) | (state==REQ2) | (startFetch & (state==IDLE | state==DONE)). It is deasserted in the cycle operandValid is high unless a new request is accepted.
- startFetch while in REQ1/REQ2 is ignored; upstream is held by stall.
- flush, any state: next state IDLE, memRead<=0, waitCnt<=0, no operandValid or fetchError pulse, operandOut retained.
- flush together with memReady: the data is discarded.
- flush together with startFetch: flush wins; the request is dropped.
- Addresses are used unmodified: no arithmetic and no wrap. An indirect pointer of 16'hFFFF is a legal address.

Optional Feature:
- Macro OPERAND_HOLD_CACHE_EN. Defined:
  - one-entry cache {cacheValid, cacheAddr, cacheData}, filled on each completed non-indirect fetch.
  - hit condition: startFetch & ~indirect & cacheValid & addrIn==cacheAddr in IDLE/DONE.
  - on a hit: go directly to DONE, memRead stays 0, operandOut<=cacheData. Latency is 1 cycle.
  - cacheValid is cleared by reset, flush, or memWrite with memWriteAddr==cacheAddr.
  - invalidation in the same cycle as a would-be hit forces a miss (normal memory fetch).
- Not defined: no cache storage; memWrite and memWriteAddr are ignored; every request goes to memory.

Test Plan:
- Single-level, memReady one cycle after memRead, addrIn=16'h0040, memory[0x0040]=16'hBEEF -> memAddr=16'h0040 with memRead=1, then operandOut=16'hBEEF with operandValid pulse 2 cycles after start; stall low afterwards.
- Indirect, addrIn=16'h0010, memory[0x0010]=16'h0200, memory[0x0200]=16'h1234 -> memAddr 16'h0010 then 16'h0200, operandOut=16'h1234 after 3 cycles, a single operandValid pulse.
- memReady held low, MAX_WAIT=8 -> memRead high for 8 cycles, fetchError pulse, state IDLE, operandOut unchanged, no operandValid.
- flush asserted in REQ2 together with memReady=1 -> memRead low next cycle, no operandValid, operandOut keeps its previous value; a new startFetch two cycles later proceeds normally.
- Back-to-back startFetch in DONE (addresses 16'h0001, 16'h0002) -> two operandValid pulses 2 cycles apart, stall continuous between them.
- With OPERAND_HOLD_CACHE_EN: fetch 16'h0040 twice -> second completes in 1 cycle with no memRead. Then a memWrite to 16'h0040 followed by a third fetch -> memRead reasserted.

Source files
------------

// File: rtl/operand_fetch_unit.sv
// Operand fetch stage: runs [addr] / [[addr]] data-memory reads and stalls upstream.
// Optional one-entry operand cache enabled by defining OPERAND_HOLD_CACHE_EN.
module operand_fetch_unit #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  startFetch,
    input  logic                  indirect,
    input  logic [ADDR_WIDTH-1:0] addrIn,
    input  logic [DATA_WIDTH-1:0] memReadData,
    input  logic                  memReady,
    input  logic                  memWrite,
    input  logic [ADDR_WIDTH-1:0] memWriteAddr,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memRead,
    output logic [DATA_WIDTH-1:0] operandOut,
    output logic                  operandValid,
    output logic                  fetchError,
    output logic                  stall
);

    typedef enum logic [1:0] {IDLE, REQ1, REQ2, DONE} state_t;

    state_t                state;
    state_t                nextState;
    logic [7:0]            waitCnt;
    logic [ADDR_WIDTH-1:0] addrLatch;
    logic                  indLatch;
    logic                  busy;
    logic                  accept;
    logic                  timeout;
    logic                  hit;
    logic [DATA_WIDTH-1:0] hitData;

    assign busy    = (state == REQ1) | (state == REQ2);
    assign accept  = startFetch & ~busy;
    assign timeout = busy & ~memReady
                   & (waitCnt == 8'(MAX_WAIT - 1));

`ifdef OPERAND_HOLD_CACHE_EN
    logic                  cacheValid;
    logic [ADDR_WIDTH-1:0] cacheAddr;
    logic [DATA_WIDTH-1:0] cacheData;
    logic                  inval;
    logic                  fill;

    // A store to the cached address in the same cycle forces a miss.
    assign inval   = memWrite & (memWriteAddr == cacheAddr);
    assign hit     = accept & ~indirect & cacheValid
                   & (addrIn == cacheAddr) & ~inval;
    assign hitData = cacheData;
    assign fill    = (state == REQ1) & memReady & ~indLatch & ~flush;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            cacheValid <= 1'b0;
            cacheAddr  <= '0;
            cacheData  <= '0;
        end else if (fill) begin
            cacheAddr  <= addrLatch;
            cacheData  <= memReadData;
            cacheValid <= ~(memWrite && memWriteAddr == addrLatch);
        end else if (inval) begin
            cacheValid <= 1'b0;
        end
    end
`else
    logic unusedBits;

    assign hit        = 1'b0;
    assign hitData    = '0;
    assign unusedBits = ^{memWrite, memWriteAddr, addrLatch};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        if (flush) begin
            nextState = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        nextState = hit ? DONE : REQ1;
                    end else begin
                        nextState = IDLE;
                    end
                end
                REQ1: begin
                    if (memReady) begin
                        nextState = indLatch ? REQ2 : DONE;
                    end else if (timeout) begin
                        nextState = IDLE;
                    end
                end
                REQ2: begin
                    if (memReady) begin
                        nextState = DONE;
                    end else if (timeout) begin
                        nextState = IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        stall = busy | accept;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt      <= '0;
            addrLatch    <= '0;
            indLatch     <= 1'b0;
            memAddr      <= '0;
            memRead      <= 1'b0;
            operandOut   <= '0;
            operandValid <= 1'b0;
            fetchError   <= 1'b0;
        end else begin
            operandValid <= 1'b0;
            fetchError   <= 1'b0;
            if (flush) begin
                memRead <= 1'b0;
                waitCnt <= '0;
            end else begin
                unique case (state)
                    IDLE, DONE: begin
                        if (hit) begin
                            operandOut   <= hitData;
                            operandValid <= 1'b1;
                        end else if (accept) begin
                            addrLatch <= addrIn;
                            indLatch  <= indirect;
                            memAddr   <= addrIn;
                            memRead   <= 1'b1;
                            waitCnt   <= '0;
                        end
                    end
                    REQ1, REQ2: begin
                        if (memReady && state == REQ1 && indLatch) begin
                            // Pointer word becomes the second read address.
                            memAddr <= memReadData;
                            waitCnt <= '0;
                        end else if (memReady) begin
                            operandOut   <= memReadData;
                            memRead      <= 1'b0;
                            operandValid <= 1'b1;
                        end else if (timeout) begin
                            memRead    <= 1'b0;
                            fetchError <= 1'b1;
                        end else begin
                            waitCnt <= waitCnt + 8'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Table-driven bench for operand_fetch_unit with a small behavioural data memory.
// Cache rows are included only when OPERAND_HOLD_CACHE_EN is defined.
module tb_operand_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        startFetch;
    logic        indirect;
    logic [15:0] addrIn;
    logic [15:0] memReadData;
    logic        memReady;
    logic        memWrite;
    logic [15:0] memWriteAddr;
    logic [15:0] memAddr;
    logic        memRead;
    logic [15:0] operandOut;
    logic        operandValid;
    logic        fetchError;
    logic        stall;
    logic        readyEn;

    int passCnt = 0;
    int totalCnt = 0;

    always #5 clk = ~clk;

    operand_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .startFetch   (startFetch),
        .indirect     (indirect),
        .addrIn       (addrIn),
        .memReadData  (memReadData),
        .memReady     (memReady),
        .memWrite     (memWrite),
        .memWriteAddr (memWriteAddr),
        .memAddr      (memAddr),
        .memRead      (memRead),
        .operandOut   (operandOut),
        .operandValid (operandValid),
        .fetchError   (fetchError),
        .stall        (stall)
    );

    function automatic logic [15:0] memfn(input logic [15:0] a);
        case (a)
            16'h0040: return 16'hBEEF;
            16'h0010: return 16'h0200;
            16'h0200: return 16'h1234;
            16'h0001: return 16'h1111;
            16'h0002: return 16'h2222;
            16'h0020: return 16'hFFFF;
            16'hFFFF: return 16'h5A5A;
            default:  return ~a;
        endcase
    endfunction

    assign memReady    = memRead & readyEn;
    assign memReadData = memfn(memAddr);

    typedef struct {
        logic        rst, fl, sf, ind;
        logic [15:0] addr;
        logic        rdy, mw;
        logic [15:0] mwa;
        logic        mr;
        logic [15:0] ma;
        logic        ov;
        logic [15:0] oo;
        logic        fe, st;
    } vec_t;

    vec_t vecs[$];

    task automatic addw(input logic rst, fl, sf, ind, input logic [15:0] addr,
                        input logic rdy, mw, input logic [15:0] mwa,
                        input logic mr, input logic [15:0] ma, input logic ov,
                        input logic [15:0] oo, input logic fe, st);
        vec_t v;
        v.rst = rst; v.fl = fl; v.sf = sf; v.ind = ind; v.addr = addr;
        v.rdy = rdy; v.mw = mw; v.mwa = mwa;
        v.mr = mr; v.ma = ma; v.ov = ov; v.oo = oo; v.fe = fe; v.st = st;
        vecs.push_back(v);
    endtask

    task automatic add(input logic rst, fl, sf, ind, input logic [15:0] addr,
                       input logic rdy, mr, input logic [15:0] ma, input logic ov,
                       input logic [15:0] oo, input logic fe, st);
        addw(rst, fl, sf, ind, addr, rdy, 1'b0, 16'h0, mr, ma, ov, oo, fe, st);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    initial begin
        int cnt;
        logic sawErr;
        logic sawOv;

        //  rst fl sf ind addr     rdy mr ma        ov oo        fe st
        add(1, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 0, 0);
        // single-level [0x0040]
        add(0, 0, 1, 0, 16'h0040, 1, 0, 16'h0000, 0, 16'h0000, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0040, 0, 16'h0000, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 1, 0, 16'h0040, 1, 16'hBEEF, 0, 0);
        add(0, 0, 0, 0, 16'h0000, 1, 0, 16'h0040, 0, 16'hBEEF, 0, 0);
        // indirect [[0x0010]]
        add(0, 0, 1, 1, 16'h0010, 1, 0, 16'h0040, 0, 16'hBEEF, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0010, 0, 16'hBEEF, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0200, 0, 16'hBEEF, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 1, 0, 16'h0200, 1, 16'h1234, 0, 0);
        add(0, 0, 0, 0, 16'h0000, 1, 0, 16'h0200, 0, 16'h1234, 0, 0);
        // back-to-back 0x0001 then 0x0002
        add(0, 0, 1, 0, 16'h0001, 1, 0, 16'h0200, 0, 16'h1234, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0001, 0, 16'h1234, 0, 1);
        add(0, 0, 1, 0, 16'h0002, 1, 0, 16'h0001, 1, 16'h1111, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0002, 0, 16'h1111, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 1, 0, 16'h0002, 1, 16'h2222, 0, 0);
        // indirect pointer 0xFFFF used unmodified
        add(0, 0, 1, 1, 16'h0020, 1, 0, 16'h0002, 0, 16'h2222, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0020, 0, 16'h2222, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 1, 1, 16'hFFFF, 0, 16'h2222, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 1, 0, 16'hFFFF, 1, 16'h5A5A, 0, 0);
        // timeout: memRead high 8 cycles, start in REQ1 ignored
        add(0, 0, 1, 0, 16'h0300, 0, 0, 16'hFFFF, 0, 16'h5A5A, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 0, 1, 16'h0300, 0, 16'h5A5A, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 0, 1, 16'h0300, 0, 16'h5A5A, 0, 1);
        add(0, 0, 1, 0, 16'h0400, 0, 1, 16'h0300, 0, 16'h5A5A, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 0, 1, 16'h0300, 0, 16'h5A5A, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 0, 1, 16'h0300, 0, 16'h5A5A, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 0, 1, 16'h0300, 0, 16'h5A5A, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 0, 1, 16'h0300, 0, 16'h5A5A, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 0, 1, 16'h0300, 0, 16'h5A5A, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0300, 0, 16'h5A5A, 1, 0);
        add(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0300, 0, 16'h5A5A, 0, 0);
        // flush in REQ2 together with memReady, then restart
        add(0, 0, 1, 1, 16'h0010, 1, 0, 16'h0300, 0, 16'h5A5A, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0010, 0, 16'h5A5A, 0, 1);
        add(0, 1, 0, 0, 16'h0000, 1, 1, 16'h0200, 0, 16'h5A5A, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 1, 0, 16'h0200, 0, 16'h5A5A, 0, 0);
        add(0, 0, 0, 0, 16'h0000, 1, 0, 16'h0200, 0, 16'h5A5A, 0, 0);
        add(0, 0, 1, 0, 16'h0040, 1, 0, 16'h0200, 0, 16'h5A5A, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0040, 0, 16'h5A5A, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 1, 0, 16'h0040, 1, 16'hBEEF, 0, 0);
        // flush with startFetch drops the request
        add(0, 1, 1, 0, 16'h0001, 1, 0, 16'h0040, 0, 16'hBEEF, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 1, 0, 16'h0040, 0, 16'hBEEF, 0, 0);
        // reset mid-fetch
        add(0, 0, 1, 0, 16'h0002, 0, 0, 16'h0040, 0, 16'hBEEF, 0, 1);
        add(1, 0, 0, 0, 16'h0000, 0, 1, 16'h0002, 0, 16'hBEEF, 0, 1);
        add(0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 0, 0);
`ifdef OPERAND_HOLD_CACHE_EN
        //   rst fl sf ind addr     rdy mw mwa       mr ma        ov oo        fe st
        addw(0, 0, 1, 0, 16'h0040, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 1);
        addw(0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 0, 1);
        addw(0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0040, 1, 16'hBEEF, 0, 0);
        addw(0, 0, 1, 0, 16'h0040, 1, 0, 16'h0000, 0, 16'h0040, 0, 16'hBEEF, 0, 1);
        addw(0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0040, 1, 16'hBEEF, 0, 0);
        addw(0, 0, 0, 0, 16'h0000, 1, 1, 16'h0040, 0, 16'h0040, 0, 16'hBEEF, 0, 0);
        addw(0, 0, 1, 0, 16'h0040, 1, 0, 16'h0000, 0, 16'h0040, 0, 16'hBEEF, 0, 1);
        addw(0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0040, 0, 16'hBEEF, 0, 1);
        addw(0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0040, 1, 16'hBEEF, 0, 0);
        addw(0, 0, 1, 0, 16'h0040, 1, 1, 16'h0040, 0, 16'h0040, 0, 16'hBEEF, 0, 1);
        addw(0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0040, 0, 16'hBEEF, 0, 1);
        addw(0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0040, 1, 16'hBEEF, 0, 0);
        addw(0, 0, 1, 0, 16'h0040, 1, 1, 16'h0041, 0, 16'h0040, 0, 16'hBEEF, 0, 1);
        addw(0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0040, 1, 16'hBEEF, 0, 0);
`endif

        reset = 1'b1; flush = 1'b0; startFetch = 1'b0; indirect = 1'b0;
        addrIn = '0; memWrite = 1'b0; memWriteAddr = '0; readyEn = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; flush = vecs[i].fl;
            startFetch = vecs[i].sf; indirect = vecs[i].ind;
            addrIn = vecs[i].addr; readyEn = vecs[i].rdy;
            memWrite = vecs[i].mw; memWriteAddr = vecs[i].mwa;
            #1;
            chk($sformatf("row%0d", i),
                64'({memRead, memAddr, operandValid, operandOut, fetchError, stall}),
                64'({vecs[i].mr, vecs[i].ma, vecs[i].ov, vecs[i].oo, vecs[i].fe, vecs[i].st}));
        end

        // Partial wait, flush, then a fresh request must wait a full window.
        @(negedge clk);
        reset = 1'b0; flush = 1'b0; memWrite = 1'b0;
        startFetch = 1'b1; indirect = 1'b0; addrIn = 16'h0500; readyEn = 1'b0;
        repeat (5) begin
            @(negedge clk);
            startFetch = 1'b0;
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        #1;
        chk("flush_drops_read", 64'(memRead), 64'(0));
        flush = 1'b0; startFetch = 1'b1; addrIn = 16'h0500;
        @(negedge clk);
        startFetch = 1'b0;
        cnt = 0; sawErr = 1'b0; sawOv = 1'b0;
        for (int k = 0; k < 40 && !sawErr; k++) begin
            #1;
            if (fetchError) sawErr = 1'b1;
            else begin
                if (memRead) cnt++;
                if (operandValid) sawOv = 1'b1;
            end
            @(negedge clk);
        end
        chk("timeout_seen", 64'(sawErr), 64'(1));
        chk("wait_cycles", 64'(cnt), 64'(8));
        chk("no_valid_on_timeout", 64'(sawOv), 64'(0));

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
